// File: rtl/mem_march_initiator.sv
// March-test BIST master for the picorv32-style native memory bus.
// Runs write P / read P / write ~P / read ~P over DEPTH words, then reports.
module mem_march_initiator #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] SEED      = 32'hA5A5_0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [31:0] first_err_addr
);

    localparam int unsigned IW = 16;
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, W_P, R_P, W_N, R_N, FIN} state_e;

    state_e         state_q, nstate_d;
    logic [IW-1:0]  idx_q, nidx_d;
    logic [TW-1:0]  tcnt_q;
    logic           mem_valid_q, busy_q, done_q, pass_q, timeout_q;
    logic [31:0]    mem_addr_q, mem_wdata_q, first_err_addr_q;
    logic [3:0]     mem_wstrb_q;
    logic [15:0]    err_count_q, err_d;
    logic [31:0]    addr_d, wdata_d, exp_c;
    logic [3:0]     wstrb_d;
    logic           hs_c, mism_c;

    function automatic logic [31:0] pat(input logic [IW-1:0] i);
        return SEED ^ {i, ~i};
    endfunction

    function automatic logic [31:0] addr_of(input logic [IW-1:0] i);
        return BASE_ADDR + {14'b0, i, 2'b00};
    endfunction

    // Handshake, compare and the next request to present after this one
    always_comb begin
        hs_c     = mem_valid_q && mem_ready;
        exp_c    = (state_q == R_N) ? ~pat(idx_q) : pat(idx_q);
        mism_c   = hs_c && (state_q == R_P || state_q == R_N) && (mem_rdata != exp_c);
        err_d    = (mism_c && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
        nstate_d = state_q;
        nidx_d   = idx_q;
        case (state_q)
            W_P: if (idx_q == LAST_IDX) begin nstate_d = R_P; nidx_d = '0; end
                 else nidx_d = idx_q + IW'(1);
            R_P: if (idx_q == LAST_IDX) begin nstate_d = W_N; nidx_d = LAST_IDX; end
                 else nidx_d = idx_q + IW'(1);
            W_N: if (idx_q == '0) begin nstate_d = R_N; nidx_d = LAST_IDX; end
                 else nidx_d = idx_q - IW'(1);
            R_N: if (idx_q == '0) nstate_d = FIN;
                 else nidx_d = idx_q - IW'(1);
            default: ;
        endcase
        addr_d  = addr_of(nidx_d);
        wstrb_d = (nstate_d == W_P || nstate_d == W_N) ? 4'hF : 4'h0;
        wdata_d = (nstate_d == W_P) ? pat(nidx_d) :
                  (nstate_d == W_N) ? ~pat(nidx_d) : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            tcnt_q           <= '0;
            mem_valid_q      <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            mem_wstrb_q      <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q          <= W_P;
                    idx_q            <= '0;
                    tcnt_q           <= '0;
                    mem_valid_q      <= 1'b1;
                    mem_addr_q       <= addr_of('0);
                    mem_wdata_q      <= pat('0);
                    mem_wstrb_q      <= 4'hF;
                    busy_q           <= 1'b1;
                    done_q           <= 1'b0;
                    pass_q           <= 1'b0;
                    timeout_q        <= 1'b0;
                    err_count_q      <= '0;
                    first_err_addr_q <= '0;
                end
                W_P, R_P, W_N, R_N: begin
                    if (hs_c) begin
                        err_count_q <= err_d;
                        if (mism_c && err_count_q == '0) first_err_addr_q <= mem_addr_q;
                        tcnt_q <= '0;
                        idx_q  <= nidx_d;
                        if (nstate_d == FIN) begin
                            state_q     <= FIN;
                            mem_valid_q <= 1'b0;
                            mem_addr_q  <= '0;
                            mem_wdata_q <= '0;
                            mem_wstrb_q <= '0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            pass_q      <= (err_d == '0) && !timeout_q;
                        end else begin
                            state_q     <= nstate_d;
                            mem_addr_q  <= addr_d;
                            mem_wdata_q <= wdata_d;
                            mem_wstrb_q <= wstrb_d;
                        end
                    end else if (tcnt_q == TO_LAST) begin
                        // Responder stalled too long: abandon the test
                        state_q     <= FIN;
                        mem_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        timeout_q   <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_valid      = mem_valid_q;
    assign mem_instr      = 1'b0;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_wstrb      = mem_wstrb_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_mem_march_initiator.sv
// Scoreboard bench for mem_march_initiator with a small SRAM responder model.
module tb_mem_march_initiator;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 5;
    localparam logic [31:0] SEED    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;

    logic [1:0]  mode;      // 0: ready high, 1: 3 wait cycles, 2: ready never
    logic        stuck;     // word 3 bit0 stuck at 1 on reads
    logic [1:0]  wait_cnt = 2'd0;
    logic [31:0] mem [DEPTH];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        t;
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, hs_cnt = 0, last_hs = 0;
    logic        stall_q = 1'b0;
    logic [31:0] st_addr, st_wdata;
    logic [3:0]  st_wstrb;

    mem_march_initiator #(
        .DEPTH(DEPTH), .BASE_ADDR(32'h0), .SEED(SEED), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_pat(input int i);
        return SEED ^ ((32'(i) << 16) | (32'(i) ^ 32'h0000_FFFF));
    endfunction

    assign mem_ready = (mode == 2'd0) ? 1'b1 : (mode == 2'd1) ? (wait_cnt == 2'd3) : 1'b0;
    assign mem_rdata = (mem_valid && mem_wstrb == 4'h0)
                     ? (mem[mem_addr[4:2]] | {31'b0, stuck && mem_addr[4:2] == 3'd3}) : 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_valid || mem_ready) wait_cnt <= 2'd0;
        else if (wait_cnt != 2'd3)   wait_cnt <= wait_cnt + 2'd1;
        if (mem_valid && mem_ready && mem_wstrb == 4'hF) mem[mem_addr[4:2]] <= mem_wdata;
    end

    // Bus monitor: request stability while stalled, and scoreboard on handshakes
    always @(negedge clk) begin
        if (!rst && mem_valid && stall_q) begin
            check("hold_addr", mem_addr, st_addr);
            check("hold_wdata", mem_wdata, st_wdata);
            check("hold_wstrb", 32'(mem_wstrb), 32'(st_wstrb));
        end
        stall_q  = !rst && mem_valid && !mem_ready;
        st_addr  = mem_addr;
        st_wdata = mem_wdata;
        st_wstrb = mem_wstrb;
        if (!rst && mem_valid && mem_ready) begin
            hs_cnt++;
            last_hs = cyc;
            check("q_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                t = exp_q.pop_front();
                check("hs_addr", mem_addr, t.addr);
                check("hs_wdata", mem_wdata, t.wdata);
                check("hs_wstrb", 32'(mem_wstrb), 32'(t.wstrb));
            end
        end
    end

    task automatic push_expected();
        for (int i = 0; i < int'(DEPTH); i++) exp_q.push_back('{32'(4*i), model_pat(i), 4'hF});
        for (int i = 0; i < int'(DEPTH); i++) exp_q.push_back('{32'(4*i), 32'h0, 4'h0});
        for (int i = int'(DEPTH) - 1; i >= 0; i--) exp_q.push_back('{32'(4*i), ~model_pat(i), 4'hF});
        for (int i = int'(DEPTH) - 1; i >= 0; i--) exp_q.push_back('{32'(4*i), 32'h0, 4'h0});
    endtask

    task automatic pulse_start(output int s);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        s = cyc;
        check("lat_valid", 32'(mem_valid), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_done_clr", 32'(done), 32'd0);
        check("first_addr", mem_addr, 32'h0);
        check("first_wdata", mem_wdata, 32'hA5A5_FFFF);
    endtask

    task automatic run(input logic [1:0] m, input logic stk, input logic [15:0] e_err,
                       input logic [31:0] e_first, input logic e_pass, input logic e_to,
                       input logic mid);
        int s, k, vcnt, hs0, hs_end;
        mode  = m;
        stuck = stk;
        exp_q.delete();
        if (m != 2'd2) push_expected();
        hs0 = hs_cnt;
        pulse_start(s);
        k = 0;
        vcnt = 0;
        while (!done && k < 2000) begin
            if (mem_valid) vcnt++;
            start = mid && (k == 5);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        if (m != 2'd2) begin
            check("hs_count", 32'(hs_cnt - hs0), 32'(4*DEPTH));
            check("done_lat", 32'(cyc), 32'(last_hs + 1));
            check("duration", 32'(last_hs - s + 1), (m == 2'd1) ? 32'(16*DEPTH) : 32'(4*DEPTH));
            check("q_drained", 32'(exp_q.size()), 32'd0);
        end else begin
            check("valid_cycles", 32'(vcnt), 32'(TIMEOUT));
        end
        check("pass", 32'(pass), 32'(e_pass));
        check("timeout", 32'(timeout), 32'(e_to));
        check("err_count", 32'(err_count), 32'(e_err));
        check("first_err", first_err_addr, e_first);
        check("end_busy", 32'(busy), 32'd0);
        hs_end = hs_cnt;
        repeat (3) @(negedge clk);
        check("done_hold", 32'(done), 32'd1);
        check("idle_valid", 32'(mem_valid), 32'd0);
        check("idle_quiet", 32'(hs_cnt), 32'(hs_end));
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_instr"}, 32'(mem_instr), 32'd0);
        check({tag, "_addr"}, mem_addr, 32'h0);
        check({tag, "_wdata"}, mem_wdata, 32'h0);
        check({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'd0);
        check({tag, "_first"}, first_err_addr, 32'h0);
    endtask

    initial begin
        int s;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;
        @(negedge clk);

        run(2'd0, 1'b0, 16'd0, 32'h0,  1'b1, 1'b0, 1'b0);
        run(2'd0, 1'b1, 16'd1, 32'hC,  1'b0, 1'b0, 1'b0);
        run(2'd1, 1'b0, 16'd0, 32'h0,  1'b1, 1'b0, 1'b0);
        run(2'd2, 1'b0, 16'd0, 32'h0,  1'b0, 1'b1, 1'b0);

        // Reset in the middle of the read-P phase with a request pending
        mode  = 2'd0;
        stuck = 1'b0;
        exp_q.delete();
        push_expected();
        pulse_start(s);
        repeat (DEPTH + 3) @(negedge clk);
        check("mid_valid", 32'(mem_valid), 32'd1);
        check("mid_rd", 32'(mem_wstrb), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        run(2'd0, 1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 1'b0);

        run(2'd0, 1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
